// File: rtl/keypad_pkg.sv
// Shared keypad types: key map, special key codes, frame-result and debounce state encodings.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_res_t;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_CAND,
        DB_PRESSED,
        DB_RELEASE
    } db_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: turns one result per scan frame into a single press pulse per key.
// state      | meaning
// DB_IDLE    | no key held
// DB_CAND    | same single key seen, counting frames toward acceptance
// DB_PRESSED | key accepted and still held; further frames of it are silent
// DB_RELEASE | key gone, counting empty frames before re-arming
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_vld_i,
    input  frame_res_t frame_res_i,
    input  logic [3:0] frame_code_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] FULL   = CW'(DEBOUNCE_SCANS);

    db_state_t     state_q;
    logic [CW-1:0] rem_q;
    logic [3:0]    cand_q;
    logic          key_valid_q;
    logic [3:0]    key_code_q;

    logic single;
    logic same;

    assign single = (frame_res_i == FR_SINGLE);
    assign same   = single && (frame_code_i == cand_q);

    // rem_q holds how many more qualifying frames are needed; the frame that
    // causes a state entry already counts as the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DB_IDLE;
            rem_q       <= '0;
            cand_q      <= 4'h0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_vld_i) begin
                case (state_q)
                    DB_IDLE: begin
                        if (single) begin
                            cand_q <= frame_code_i;
                            if (RELOAD == '0) begin
                                state_q     <= DB_PRESSED;
                                key_valid_q <= 1'b1;
                                key_code_q  <= frame_code_i;
                            end else begin
                                state_q <= DB_CAND;
                                rem_q   <= RELOAD;
                            end
                        end
                    end
                    DB_CAND: begin
                        if (!single) begin
                            state_q <= DB_IDLE;
                        end else if (!same) begin
                            cand_q <= frame_code_i;
                            rem_q  <= RELOAD;
                        end else if (rem_q == CW'(1)) begin
                            state_q     <= DB_PRESSED;
                            key_valid_q <= 1'b1;
                            key_code_q  <= cand_q;
                        end else begin
                            rem_q <= rem_q - CW'(1);
                        end
                    end
                    DB_PRESSED: begin
                        if (!same) begin
                            if (single) begin
                                state_q <= DB_RELEASE;
                                rem_q   <= FULL;
                            end else if (RELOAD == '0) begin
                                state_q <= DB_IDLE;
                            end else begin
                                state_q <= DB_RELEASE;
                                rem_q   <= RELOAD;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        if (same) begin
                            state_q <= DB_PRESSED;
                        end else if (single) begin
                            rem_q <= FULL;
                        end else if (rem_q == CW'(1)) begin
                            state_q <= DB_IDLE;
                        end else begin
                            rem_q <= rem_q - CW'(1);
                        end
                    end
                    default: state_q <= DB_IDLE;
                endcase
            end
        end
    end

    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_scan_entry.sv
// Matrix keypad scanner with frame debounce and BCD entry buffer confirmed by '#'.
// Optional KEYPAD_STAR_CLEAR_EN: '*' clears the pending (unconfirmed) entry.
module keypad_scan_entry
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROWS-1:0]       row_n,
    output logic [COLS-1:0]       col_n,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            digit_count,
    output logic                  entry_valid,
    input  logic                  entry_ack
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DW   = 4 * DIGITS;
    localparam logic [DIVW-1:0] DIV_RELOAD = DIVW'(SCAN_DIV - 1);
    localparam logic [1:0]      COL_LAST   = 2'(COLS - 1);
    localparam logic [3:0]      DIGITS_MAX = 4'(DIGITS);

    function automatic logic [COLS-1:0] col_drive(input logic [1:0] c);
        return ~(COLS'(1) << c);
    endfunction

    logic            scan_on_q;
    logic [1:0]      col_q;
    logic [1:0]      col_nxt;
    logic [DIVW-1:0] div_q;
    logic [COLS-1:0] col_n_q;
    logic [ROWS-1:0] row_s1_q;
    logic [ROWS-1:0] row_s2_q;

    assign col_nxt = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;

    // One idle cycle after reset keeps the first column window a full SCAN_DIV long.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_on_q <= 1'b0;
            col_q     <= 2'd0;
            div_q     <= DIV_RELOAD;
            col_n_q   <= '1;
        end else if (!scan_on_q) begin
            scan_on_q <= 1'b1;
            col_n_q   <= col_drive(2'd0);
        end else if (div_q == '0) begin
            div_q   <= DIV_RELOAD;
            col_q   <= col_nxt;
            col_n_q <= col_drive(col_nxt);
        end else begin
            div_q <= div_q - DIVW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= '1;
            row_s2_q <= '1;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    logic       sample;
    logic       frame_vld;
    logic [1:0] acc_cnt_q;
    logic [1:0] acc_row_q;
    logic [1:0] acc_col_q;
    logic [1:0] hit_cnt;
    logic [1:0] hit_row;
    logic [2:0] tot;
    logic [1:0] tot_sat;
    logic [1:0] key_row;
    logic [1:0] key_col;
    frame_res_t frame_res;
    logic [3:0] frame_code;

    assign sample    = scan_on_q && (div_q == '0);
    assign frame_vld = sample && (col_q == COL_LAST);

    // Key counts saturate at 2: anything beyond one key is simply MULTI.
    always_comb begin
        hit_cnt = 2'd0;
        hit_row = 2'd0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s2_q[r]) begin
                hit_row = 2'(r);
                if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
            end
        end
        tot     = 3'(acc_cnt_q) + 3'(hit_cnt);
        tot_sat = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        key_row = (hit_cnt == 2'd1) ? hit_row : acc_row_q;
        key_col = (hit_cnt == 2'd1) ? col_q : acc_col_q;
        frame_res = FR_NONE;
        if (tot_sat == 2'd1) frame_res = FR_SINGLE;
        else if (tot_sat == 2'd2) frame_res = FR_MULTI;
        frame_code = KEYMAP[key_row][key_col];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q <= 2'd0;
            acc_row_q <= 2'd0;
            acc_col_q <= 2'd0;
        end else if (sample) begin
            if (col_q == COL_LAST) begin
                acc_cnt_q <= 2'd0;
                acc_row_q <= 2'd0;
                acc_col_q <= 2'd0;
            end else begin
                acc_cnt_q <= tot_sat;
                acc_row_q <= key_row;
                acc_col_q <= key_col;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_vld_i  (frame_vld),
        .frame_res_i  (frame_res),
        .frame_code_i (frame_code),
        .key_valid_o  (key_valid),
        .key_code_o   (key_code)
    );

    logic [DW-1:0] digits_q;
    logic [3:0]    count_q;
    logic          entry_valid_q;

    // Acknowledge takes priority over a key arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q      <= '0;
            count_q       <= 4'd0;
            entry_valid_q <= 1'b0;
        end else if (entry_valid_q && entry_ack) begin
            digits_q      <= '0;
            count_q       <= 4'd0;
            entry_valid_q <= 1'b0;
        end else if (key_valid && !entry_valid_q) begin
            if (is_digit(key_code)) begin
                if (count_q < DIGITS_MAX) begin
                    digits_q <= (digits_q << 4) | DW'(key_code);
                    count_q  <= count_q + 4'd1;
                end
            end else if (key_code == KEY_HASH) begin
                if (count_q != 4'd0) entry_valid_q <= 1'b1;
            end
`ifdef KEYPAD_STAR_CLEAR_EN
            else if (key_code == KEY_STAR) begin
                digits_q <= '0;
                count_q  <= 4'd0;
            end
`endif
        end
    end

    assign col_n       = col_n_q;
    assign digits      = digits_q;
    assign digit_count = count_q;
    assign entry_valid = entry_valid_q;

endmodule
